// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the load/store path: funct3 size codes, LSU states,
// opcode constants and lane helpers for byte enables and store data replication.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} lsu_state_t;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} acc_size_t;

  // Reserved encodings fall through to a word access.
  function automatic acc_size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = SZ_B;
      F3_H, F3_HU: access_size = SZ_H;
      default:     access_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input acc_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    byte_enable = 4'b0001 << off;
      SZ_H:    byte_enable = 4'b0011 << {off[1], 1'b0};
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input acc_size_t sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    store_data = {4{wd[7:0]}};
      SZ_H:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load data formatter: picks the byte/half lane from the read word
// and sign- or zero-extends it according to funct3.
module load_formatter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension; half lanes ignore off[0].
  always_comb begin
    byte_s = 8'(rdata >> {off, 3'b000});
    half_s = 16'(rdata >> {off[1], 4'b0000});
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_s};
      F3_H:    result = {{(XLEN-16){half_s[15]}}, half_s};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: req/ack data-memory bus master with pipeline stall and load formatting.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into a one-cycle exception.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] rdata_out,
  output logic            misalign_exc,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_r, next_s;
  logic [1:0]      off_r;
  logic [2:0]      f3_r;
  logic            load_r;
  logic            acc_s;
  logic            misalign_s;
  acc_size_t       size_s;
  logic [XLEN-1:0] fmt_s;

  assign acc_s  = MemRead | MemWrite;
  assign size_s = access_size(funct3);

`ifdef MISALIGN_TRAP_EN
  assign misalign_s = ((size_s == SZ_H) && addr[0]) ||
                      ((size_s == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .rdata  (mem_rdata),
    .off    (off_r),
    .funct3 (f3_r),
    .result (fmt_s)
  );

  // Stall holds the pipeline from strobe detection until the response cycle.
  always_comb begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = ((state_r == IDLE) && acc_s) || (state_r == REQ);
    end
  end

  // Next-state logic; misaligned traps skip the bus phase entirely.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          if (misalign_s) next_s = RESP;
          else            next_s = REQ;
        end else begin
          next_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) next_s = RESP;
        else         next_s = REQ;
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, latched access info and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      off_r        <= 2'b00;
      f3_r         <= 3'b000;
      load_r       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= 4'b0000;
      rdata_out    <= '0;
      load_valid   <= 1'b0;
      misalign_exc <= 1'b0;
    end else begin
      state_r      <= next_s;
      load_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      case (state_r)
        IDLE: begin
          if (acc_s) begin
            off_r  <= addr[1:0];
            f3_r   <= funct3;
            load_r <= ~MemWrite;
            if (misalign_s) begin
              misalign_exc <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_be    <= byte_enable(size_s, addr[1:0]);
              mem_wdata <= store_data(size_s, wdata);
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (load_r) begin
              rdata_out  <= fmt_s;
              load_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed accesses against a byte-lane model.
module tb_mem_access_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, misalign_exc, mem_req, mem_we, mem_ack;
  logic [31:0] rdata_out, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  logic        exp_we;
  bit          exp_active = 1'b0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic        last_we = 1'b0;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_valid(load_valid),
    .rdata_out(rdata_out), .misalign_exc(misalign_exc), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: access width in bytes, starting byte lane, and derived bus/load values.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    else if (f3 == 3'b001 || f3 == 3'b101) return 2;
    else return 4;
  endfunction

  function automatic int lane(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    if (n == 4) return 0;
    if (n == 2) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << nbytes(f3)) - 1) << lane(f3, a));
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = nbytes(f3);
    logic [31:0] v, mask;
    v    = rd >> (8 * lane(f3, a));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    v    = v & mask;
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (nbytes(f3) == 2 && a[0]) || (nbytes(f3) == 4 && a[1:0] != 2'b00);
`else
    return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Per-cycle compare of the bus and load result against the model.
  always @(negedge clk) begin
    if (!rst && exp_active && mem_req) begin
      chk("bus_addr", mem_addr, exp_addr);
      chk("bus_be", {28'h0, mem_be}, {28'h0, exp_be});
      chk("bus_we", {31'h0, mem_we}, {31'h0, exp_we});
      if (exp_we) chk("bus_wdata", mem_wdata, exp_wdata);
    end
    if (!rst && load_valid) chk("rdata_out", rdata_out, exp_rdata);
  end

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int stall_cnt = 0, lv_cnt = 0, mx_cnt = 0, req_cnt = 0, waited = 0, resp_c = -1;
    bit mis;
    logic [31:0] prev_rd;
    mis       = model_mis(f3, a);
    prev_rd   = rdata_out;
    exp_we    = st;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = model_be(f3, a);
    exp_wdata = model_wd(f3, wd);
    exp_rdata = model_load(f3, a, rd);
    exp_active = 1'b1;
    @(posedge clk); #1;
    MemRead = ~st; MemWrite = st; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        addr  = a ^ 32'h0000_0F03;
        wdata = ~wd;
      end
      if (mem_req) begin
        mem_ack   = (waited == dly);
        mem_rdata = (waited == dly) ? rd : (32'hC3C3_0000 | 32'(c));
        waited++;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      if (stall) stall_cnt++;
      if (load_valid) lv_cnt++;
      if (misalign_exc) mx_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_addr = mem_addr; last_be = mem_be; last_we = mem_we; last_wdata = mem_wdata;
      end
      if (c > 0 && !stall) begin
        resp_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("resp_cycle", 32'(resp_c), mis ? 32'd1 : 32'(2 + dly));
    chk("stall_cycles", 32'(stall_cnt), mis ? 32'd1 : 32'(2 + dly));
    chk("req_cycles", 32'(req_cnt), mis ? 32'd0 : 32'(1 + dly));
    chk("load_valid_pulses", 32'(lv_cnt), (!st && !mis) ? 32'd1 : 32'd0);
    chk("misalign_pulses", 32'(mx_cnt), mis ? 32'd1 : 32'd0);
    chk("load_valid_drop", {31'h0, load_valid}, 32'h0);
    if (mis) chk("rdata_kept", rdata_out, prev_rd);
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = F3_W; addr = 32'h0;
    wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_rdata", rdata_out, 32'h0);
    chk("rst_be", {28'h0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_misalign", {31'h0, misalign_exc}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;

    access(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_be", {28'h0, last_be}, 32'hF);
    chk("sw_addr", last_addr, 32'h100);
    chk("sw_we", {31'h0, last_we}, 32'h1);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);

    access(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    chk("lb_lit", rdata_out, 32'hFFFF_FF80);
    access(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_FF7F, 0);
    chk("lbu_lit", rdata_out, 32'h0000_0080);

    access(1'b1, F3_H, 32'h102, 32'h1234_ABCD, 32'h0, 0);
    chk("sh_be", {28'h0, last_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);

    access(1'b0, F3_W, 32'h200, 32'h0, 32'h1357_9BDF, 4);
    chk("lw_wait_lit", rdata_out, 32'h1357_9BDF);

    access(1'b0, F3_H, 32'h102, 32'h0, 32'h8001_7FFF, 1);
    chk("lh_lit", rdata_out, 32'hFFFF_8001);
    access(1'b0, F3_HU, 32'h100, 32'h0, 32'h1234_F00D, 0);
    chk("lhu_lit", rdata_out, 32'h0000_F00D);
    access(1'b1, F3_B, 32'h101, 32'h0000_00A5, 32'h0, 2);
    chk("sb_be", {28'h0, last_be}, 32'h2);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    access(1'b0, 3'b011, 32'h104, 32'h0, 32'hCAFE_F00D, 0);
    chk("rsvd_word_lit", rdata_out, 32'hCAFE_F00D);
    chk("rsvd_word_be", {28'h0, last_be}, 32'hF);
    access(1'b0, F3_B, 32'h100, 32'h0, 32'h0000_007F, 0);
    chk("lb_pos_lit", rdata_out, 32'h0000_007F);

    // Reset while a request is outstanding, then a late ack.
    exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF; exp_rdata = 32'h0; exp_active = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = F3_W; addr = 32'h300; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_req_up", {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_stall_forced", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstmid_req_drop", {31'h0, mem_req}, 32'h0);
    chk("rstmid_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0; exp_active = 1'b0;
    @(negedge clk);
    chk("late_ack_req", {31'h0, mem_req}, 32'h0);
    chk("late_ack_lv", {31'h0, load_valid}, 32'h0);
    chk("late_ack_rdata", rdata_out, 32'h0);

    access(1'b0, F3_W, 32'h101, 32'h0, 32'h7654_3210, 0);
`ifndef MISALIGN_TRAP_EN
    chk("mis_lw_addr", last_addr, 32'h100);
    chk("mis_lw_be", {28'h0, last_be}, 32'hF);
    chk("mis_lw_data", rdata_out, 32'h7654_3210);
`endif
    access(1'b1, F3_H, 32'h103, 32'h0000_BEEF, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
